// File: rtl/i2c_master.sv
// Single-master I2C controller: START, 7-bit address + R/W, two payload bytes, STOP.
// Optional SCL clock stretching is enabled with `define I2C_MASTER_CLK_STRETCH_EN.
module i2c_master #(
  parameter int CLK_DIV = 16,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [11:0]       wr_data,
  output logic [11:0]       rd_data,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  inout  wire               scl,
  inout  wire               sda
);

  localparam int            QW   = $clog2(CLK_DIV);
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP
  } state_t;

  state_t            state;
  logic [QW-1:0]     qcnt;
  logic [1:0]        phase;
  logic [2:0]        bit_cnt;
  logic              byte_idx;
  logic [7:0]        tx_shift;
  logic [7:0]        rx_shift;
  logic [7:0]        rd_hi;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [11:0]       wr_q;
  logic              ack_smp;
  logic              scl_oe;
  logic              sda_oe;
  logic              tick;
  logic              stall;

  assign scl  = scl_oe ? 1'b0 : 1'bz;
  assign sda  = sda_oe ? 1'b0 : 1'bz;
  assign tick = (qcnt == QMAX);

`ifdef I2C_MASTER_CLK_STRETCH_EN
  logic scl_s1;
  logic scl_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
    end
  end

  // Only the Q2->Q3 advance waits for SCL; the synchroniser lag is hidden inside Q2.
  assign stall = (phase == 2'd2) && tick && !scl_s2;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      qcnt     <= '0;
      phase    <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_idx <= 1'b0;
      tx_shift <= 8'd0;
      rx_shift <= 8'd0;
      rd_hi    <= 8'd0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wr_q     <= 12'd0;
      ack_smp  <= 1'b0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      rd_data  <= 12'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        scl_oe <= 1'b0;
        sda_oe <= 1'b0;
        qcnt   <= '0;
        phase  <= 2'd0;
        // A request landing in the done cycle is dropped; the next cycle accepts.
        if (start && !done) begin
          rw_q     <= rw;
          addr_q   <= addr;
          wr_q     <= wr_data;
          ack_err  <= 1'b0;
          busy     <= 1'b1;
          bit_cnt  <= 3'd0;
          byte_idx <= 1'b0;
          state    <= START;
        end else begin
          busy <= 1'b0;
        end
      end else begin
        if (!tick) begin
          qcnt <= qcnt + QW'(1);
        end else if (!stall) begin
          qcnt  <= '0;
          phase <= phase + 2'd1;
        end

        // SDA moves one cycle after SCL has fallen, so it never races the SCL edge.
        if (phase == 2'd0 && qcnt == '0) begin
          case (state)
            ADDR, WR_BYTE: sda_oe <= ~tx_shift[7];
            RD_ACK:        sda_oe <= ~byte_idx;
            STOP:          sda_oe <= 1'b1;
            default:       sda_oe <= 1'b0;
          endcase
        end

        if (phase == 2'd3 && qcnt == '0) begin
          ack_smp <= sda;
          if (state == RD_BYTE) rx_shift <= {rx_shift[6:0], sda};
        end

        if (tick && !stall) begin
          case (phase)
            2'd1: begin
              scl_oe <= 1'b0;
              if (state == START) sda_oe <= 1'b1;
            end
            2'd2: begin
              if (state == STOP) sda_oe <= 1'b0;
            end
            2'd3: begin
              scl_oe <= (state != STOP);
              case (state)
                START: begin
                  tx_shift <= {addr_q, rw_q};
                  bit_cnt  <= 3'd0;
                  state    <= ADDR;
                end
                ADDR, WR_BYTE: begin
                  if (bit_cnt == 3'd7) begin
                    state <= (state == ADDR) ? ADDR_ACK : WR_ACK;
                  end else begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    tx_shift <= {tx_shift[6:0], 1'b0};
                  end
                end
                ADDR_ACK: begin
                  if (ack_smp) begin
                    ack_err <= 1'b1;
                    state   <= STOP;
                  end else begin
                    bit_cnt  <= 3'd0;
                    byte_idx <= 1'b0;
                    tx_shift <= wr_q[11:4];
                    state    <= rw_q ? RD_BYTE : WR_BYTE;
                  end
                end
                WR_ACK: begin
                  if (ack_smp) begin
                    ack_err <= 1'b1;
                    state   <= STOP;
                  end else if (!byte_idx) begin
                    byte_idx <= 1'b1;
                    bit_cnt  <= 3'd0;
                    tx_shift <= {wr_q[3:0], 4'b0000};
                    state    <= WR_BYTE;
                  end else begin
                    state <= STOP;
                  end
                end
                RD_BYTE: begin
                  if (bit_cnt == 3'd7) state <= RD_ACK;
                  else                 bit_cnt <= bit_cnt + 3'd1;
                end
                RD_ACK: begin
                  // The upper byte is staged so rd_data changes only once per read.
                  if (!byte_idx) begin
                    rd_hi    <= rx_shift;
                    byte_idx <= 1'b1;
                    bit_cnt  <= 3'd0;
                    state    <= RD_BYTE;
                  end else begin
                    rd_data <= {rd_hi, rx_shift[7:4]};
                    state   <= STOP;
                  end
                end
                STOP: begin
                  done  <= 1'b1;
                  state <= IDLE;
                end
                default: state <= IDLE;
              endcase
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
